prog_loader: RTL

Boot sequencer and memory-port owner for the LC-3 core. It takes a flat program image: word 0 is the `.ORIG` address, and words 1..N-1 are code. It writes the code words into unified memory at consecutive addresses from origin, then releases the core with PC initialised to origin. After boot it passes core memory traffic straight to memory, and it re-arbitrates ownership whenever a reload is requested.

---
 rtl/lc3_pkg.sv | 22 ++
 rtl/prog_loader_mem_port_mux.sv | 30 +++
 rtl/prog_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 boot definitions: word/address widths, loader state encoding and
// a helper that pulls one 16-bit word out of a flat program image.
package lc3_pkg;

   localparam int WORD_W    = 16;
   localparam int ADDR_W    = 16;
   // Widest image the helper can index; loader images are zero-extended to this.
   localparam int IMG_MAX_W = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ORIG  = 2'd1,
      WRITE = 2'd2,
      RUN   = 2'd3
   } loader_state_t;

   function automatic logic [WORD_W-1:0] image_word(input logic [IMG_MAX_W-1:0] img,
                                                    input int i);
      return img[i*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/prog_loader_mem_port_mux.sv
// Memory port owner select: the loader write port drives memory until own_cpu
// is set, after which the core port passes straight through and gets the ack.
module mem_port_mux import lc3_pkg::*; #(
   parameter int ADDR_W = 16
) (
   input  logic              own_cpu,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_wdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_ack
);

   assign mem_req   = own_cpu ? cpu_req   : ld_req;
   assign mem_we    = own_cpu ? cpu_we    : ld_we;
   assign mem_addr  = own_cpu ? cpu_addr  : ld_addr;
   assign mem_wdata = own_cpu ? cpu_wdata : ld_wdata;
   // The core never sees an ack that belongs to a loader write.
   assign cpu_ack   = own_cpu & mem_ack;

endmodule

// File: rtl/prog_loader.sv
// LC-3 boot sequencer: copies image words 1..N-1 to memory starting at the
// origin held in word 0, then hands the memory port and PC origin to the core.
module prog_loader import lc3_pkg::*; #(
   parameter int SIZE   = 80,
   parameter int ADDR_W = lc3_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SIZE-1:0]   prog_image,
   input  logic              load_start,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [15:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              cpu_run,
   output logic [15:0]       pc_init,
   output logic              load_done,
   output logic              busy,
   output logic              wrap_err,
   output logic [1:0]        dbg_state
);

   localparam int N     = SIZE / WORD_W;
   localparam int IDX_W = $clog2(N + 1);

   if (SIZE % WORD_W != 0 || SIZE < WORD_W || SIZE > IMG_MAX_W) begin : g_size_chk
      $error("prog_loader: SIZE must be a multiple of 16 in [16, %0d]", IMG_MAX_W);
   end

   loader_state_t            state;
   logic [SIZE-1:0]          img_q;
   logic [IMG_MAX_W-1:0]     img_ext;
   logic [IDX_W-1:0]         idx;
   logic [ADDR_W-1:0]        wr_addr;
   logic [WORD_W-1:0]        wr_data;
   logic                     wr_req;
   logic                     reload_pend;
   logic                     accept;

   assign img_ext   = IMG_MAX_W'(img_q);
   assign dbg_state = state;

   // A reload from RUN waits for the core to drop cpu_req so no access is cut.
   assign accept = (state == IDLE && load_start) ||
                   (state == RUN && (load_start || reload_pend) && !cpu_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         img_q       <= '0;
         idx         <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         wr_req      <= 1'b0;
         reload_pend <= 1'b0;
         cpu_run     <= 1'b0;
         pc_init     <= '0;
         load_done   <= 1'b0;
         busy        <= 1'b0;
         wrap_err    <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (accept) begin
            state       <= ORIG;
            img_q       <= prog_image;
            wrap_err    <= 1'b0;
            cpu_run     <= 1'b0;
            busy        <= 1'b1;
            reload_pend <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               ORIG: begin
                  pc_init <= image_word(img_ext, 0);
                  idx     <= IDX_W'(1);
                  if (N == 1) begin
                     state     <= RUN;
                     cpu_run   <= 1'b1;
                     load_done <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state   <= WRITE;
                     wr_req  <= 1'b1;
                     wr_addr <= ADDR_W'(image_word(img_ext, 0));
                     wr_data <= image_word(img_ext, 1);
                  end
               end
               WRITE: begin
                  if (mem_ack) begin
                     if (idx == IDX_W'(N - 1)) begin
                        state     <= RUN;
                        wr_req    <= 1'b0;
                        cpu_run   <= 1'b1;
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                     end else if (wr_addr == '1) begin
                        // Last address just written; the next word would wrap.
                        state    <= IDLE;
                        wr_req   <= 1'b0;
                        busy     <= 1'b0;
                        wrap_err <= 1'b1;
                     end else begin
                        idx     <= idx + IDX_W'(1);
                        wr_addr <= wr_addr + ADDR_W'(1);
                        wr_data <= image_word(img_ext, int'(idx) + 1);
                     end
                  end
               end
               RUN: begin
                  if (load_start && cpu_req) reload_pend <= 1'b1;
               end
            endcase
         end
      end
   end

   mem_port_mux #(.ADDR_W(ADDR_W)) u_mux (
      .own_cpu   (cpu_run),
      .ld_req    (wr_req),
      .ld_we     (wr_req),
      .ld_addr   (wr_addr),
      .ld_wdata  (wr_data),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_ack   (cpu_ack)
   );

endmodule
